// File: rtl/wb_apb_bridge_mc.sv
// Wishbone B4 classic slave to APB4 master bridge with address-decoded fan-out
// to NUM_SLAVES peripherals; slave errors, decode misses and timeouts become err_o.
module wb_apb_bridge_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_SEL_LSB    = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [ADDR_WIDTH-1:0]     adr_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic [DATA_WIDTH/8-1:0]   sel_i,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic                      we_i,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      rty_o,
  output logic [DATA_WIDTH-1:0]     dat_o,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [NUM_SLAVES-1:0]     psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  localparam int SEL_WIDTH  = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic                    pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
  logic [SEL_WIDTH-1:0]    pstrb_q,   pstrb_d;
  logic [NUM_SLAVES-1:0]   psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    ack_q,     ack_d;
  logic                    err_q,     err_d;
  logic [DATA_WIDTH-1:0]   dat_q,     dat_d;

  logic [IDX_W-1:0]        req_idx;
  logic                    req_hit;
  logic [NUM_SLAVES-1:0]   req_onehot;

  always_comb begin
    req_idx = adr_i[SLV_SEL_LSB +: IDX_W];
    req_hit = (int'(req_idx) < NUM_SLAVES);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      req_onehot[i] = (req_idx == IDX_W'(i));
    end
  end

  // ack/err are registered on the edge entering RESP, so they are high exactly
  // while RESP lasts; a master that dropped cyc_i by then gets no response.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    cnt_d     = cnt_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          paddr_d  = adr_i;
          pwrite_d = we_i;
          pwdata_d = dat_i;
          pstrb_d  = we_i ? sel_i : '0;
          if (req_hit) begin
            psel_d  = req_onehot;
            state_d = SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (pready) begin
          psel_d    = '0;
          penable_d = 1'b0;
          ack_d     = cyc_i & ~pslverr;
          err_d     = cyc_i & pslverr;
          if (!pwrite_q && !pslverr) begin
            dat_d = prdata;
          end
          state_d = RESP;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          err_d     = cyc_i;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rty_o   = 1'b0;
  assign dat_o   = dat_q;
  assign paddr   = paddr_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;

endmodule

// File: tb/tb_wb_apb_bridge_mc.sv
// Scoreboard bench for wb_apb_bridge_mc: a Wishbone driver, a behavioural APB
// slave with its own memory, and a response monitor checked against a reference model.
module tb_wb_apb_bridge_mc;

  localparam int NS = 3;
  localparam int TO = 8;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b1;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel_i = '0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i = 1'b0;
  logic        ack_o, err_o, rty_o;
  logic [31:0] dat_o, paddr, pwdata;
  logic [NS-1:0] psel;
  logic        penable, pwrite;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  always #5 pclk = ~pclk;

  // Three slaves on a 2-bit select field: field value 3 is an unmapped hole.
  wb_apb_bridge_mc #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS),
    .SLV_SEL_LSB(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o), .dat_o(dat_o),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [3:0]  sel;
    bit          we;
    bit          slverr;
    bit          exp_err;
    int          waits;
    int          lat;
    int          issue;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  txn_t mon_t;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] last_rd = '0;
  int n_checks = 0;
  int n_fail = 0;
  int resp_cnt = 0;
  int cyc_n = 0;
  int acc_k = 0;

  always @(posedge pclk) cyc_n++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Unwritten locations read as the inverted word address.
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] k = {a[31:2], 2'b00};
    return ref_mem.exists(k) ? ref_mem[k] : ~k;
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    logic [31:0] k = {a[31:2], 2'b00};
    return slv_mem.exists(k) ? slv_mem[k] : ~k;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_dat_o"}, dat_o, 32'd0);
    check_output({tag, "_paddr"}, paddr, 32'd0);
    check_output({tag, "_pwdata"}, pwdata, 32'd0);
    check_output({tag, "_ctrl"}, 32'({ack_o, err_o, rty_o, psel, penable, pwrite, pstrb}), 32'd0);
  endtask

  // Model the outcome from the bridge's rules, queue it, then run one WB cycle.
  task automatic apply_stimulus(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                                input bit we, input int waits, input bit slverr, input bit abandon);
    txn_t t;
    int   start;
    int   k;
    t.adr = adr; t.wdat = wdat; t.sel = sel; t.we = we; t.waits = waits; t.slverr = slverr;
    if (int'(adr[13:12]) >= NS) begin
      t.exp_err = 1'b1;
      t.lat = -1;
    end else if (waits >= TO) begin
      t.exp_err = 1'b1;
      t.lat = 1 + TO;
    end else begin
      t.exp_err = slverr;
      t.lat = 2 + waits;
      if (!slverr) begin
        if (we) ref_mem[{adr[31:2], 2'b00}] = merge(ref_read(adr), wdat, sel);
        else last_rd = ref_read(adr);
      end
    end
    t.rdat = last_rd;
    @(negedge pclk);
    t.issue = cyc_n + 1;
    cur = t;
    if (!abandon) exp_q.push_back(t);
    adr_i = adr; dat_i = wdat; sel_i = sel; we_i = we;
    cyc_i = 1'b1; stb_i = 1'b1;
    if (abandon) begin
      repeat (2) @(negedge pclk);
      cyc_i = 1'b0; stb_i = 1'b0;
      k = 0;
      while (psel != '0 && k < 50) begin @(negedge pclk); k++; end
      if (k == 50) check_output("abandon_psel_release", 32'(psel), 32'd0);
      repeat (2) @(negedge pclk);
    end else begin
      start = resp_cnt;
      k = 0;
      while (resp_cnt == start && k < 200) begin @(negedge pclk); k++; end
      if (resp_cnt == start) check_output("resp_wait_bound", 32'd0, 32'd1);
      cyc_i = 1'b0; stb_i = 1'b0;
    end
  endtask

  // Behavioural APB slave: checks the setup phase, then inserts cur.waits wait states.
  always @(negedge pclk) begin
    if (psel != '0) begin
      if (!penable) begin
        acc_k = 0;
        check_output("setup_psel", 32'(psel), 32'(1 << cur.adr[13:12]));
        check_output("setup_paddr", paddr, cur.adr);
        check_output("setup_pwrite", 32'(pwrite), 32'(cur.we));
        check_output("setup_pstrb", 32'(pstrb), cur.we ? 32'(cur.sel) : 32'd0);
        if (cur.we) check_output("setup_pwdata", pwdata, cur.wdat);
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      end else begin
        pready  = (acc_k == cur.waits);
        pslverr = pready & cur.slverr;
        prdata  = pready ? slv_read(paddr) : $urandom;
        if (pready && pwrite && !cur.slverr)
          slv_mem[{paddr[31:2], 2'b00}] = merge(slv_read(paddr), pwdata, pstrb);
        acc_k++;
      end
    end else begin
      check_output("penable_without_psel", 32'(penable), 32'd0);
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    end
  end

  // Monitor: every ack/err pulse is matched against the oldest expected response.
  always @(posedge pclk) begin
    #1;
    if (preset_n && (ack_o || err_o)) begin
      check_output("ack_err_exclusive", 32'(ack_o & err_o), 32'd0);
      check_output("rty_o", 32'(rty_o), 32'd0);
      if (exp_q.size() == 0) begin
        check_output("spurious_resp", 32'({ack_o, err_o}), 32'd0);
      end else begin
        mon_t = exp_q.pop_front();
        check_output("resp_err", 32'(err_o), 32'(mon_t.exp_err));
        check_output("resp_ack", 32'(ack_o), 32'(!mon_t.exp_err));
        check_output("resp_dat_o", dat_o, mon_t.rdat);
        if (mon_t.lat >= 0) check_output("resp_latency", 32'(cyc_n - mon_t.issue), 32'(mon_t.lat));
      end
      resp_cnt++;
    end
  end

  initial begin
    int k;
    logic [31:0] a;
    int r;
    int w;
    $display("[TB] start");
    #2 preset_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;

    apply_stimulus(32'h0000_1004, 32'hA5A5_5A5A, 4'h3, 1'b1, 0, 1'b0, 1'b0);
    apply_stimulus(32'h0000_1004, 32'h0,         4'hF, 1'b0, 3, 1'b0, 1'b0);
    apply_stimulus(32'h0000_2008, 32'h1234_5678, 4'hF, 1'b1, 0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_2008, 32'h0,         4'hF, 1'b0, 1, 1'b0, 1'b0);
    apply_stimulus(32'h0000_3010, 32'h0,         4'hF, 1'b0, 0, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b1, 1000, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0000, 32'h0,         4'hF, 1'b0, TO - 1, 1'b0, 1'b0);
    apply_stimulus(32'h0000_1004, 32'h0,         4'hF, 1'b0, 2, 1'b1, 1'b0);
    apply_stimulus(32'h0000_200C, 32'h0BAD_C0DE, 4'hC, 1'b1, 2, 1'b0, 1'b1);
    apply_stimulus(32'h0000_200C, 32'h0,         4'h0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 16));
      r = $urandom_range(0, 9);
      w = (r < 6) ? (r % 4) : (r == 6) ? TO - 1 : (r == 7) ? TO : 1;
      apply_stimulus(a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom),
                     w, ($urandom_range(0, 7) == 0), 1'b0);
    end

    // Reset in the middle of an ACCESS phase against a stalled slave.
    @(negedge pclk);
    cur.adr = 32'h0000_2000; cur.wdat = 32'h7777_1111; cur.sel = 4'hF; cur.we = 1'b1;
    cur.waits = 1000; cur.slverr = 1'b0;
    adr_i = cur.adr; dat_i = cur.wdat; sel_i = cur.sel; we_i = 1'b1;
    cyc_i = 1'b1; stb_i = 1'b1;
    k = 0;
    while (!penable && k < 20) begin @(negedge pclk); k++; end
    check_output("reached_access", 32'(penable), 32'd1);
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1 check_reset_outputs("mid_access_reset");
    cyc_i = 1'b0; stb_i = 1'b0;
    exp_q.delete();
    last_rd = '0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;

    apply_stimulus(32'h0000_2000, 32'h1357_9BDF, 4'hF, 1'b1, 0, 1'b0, 1'b0);
    apply_stimulus(32'h0000_2000, 32'h0,         4'hF, 1'b0, 1, 1'b0, 1'b0);

    repeat (4) @(negedge pclk);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
